// File: rtl/ex_wb_pipe_regs_if.sv
// Bundles the EX-side operand, forwarding-qualifier and data-memory signals of the EX/MEM/WB register block.
// No storage of its own; latency belongs to the module that drives the slave modport.
// stall travels with the bundle and freezes both pipeline registers in the attached block.
interface ex_wb_pipe_regs_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Pipeline control from the hazard unit.
  logic              stall;
  logic              flush_ex;

  // EX-stage instruction fields.
  logic              ex_valid;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_MemtoReg;
  logic [REG_AW-1:0] ex_WriteRegister;
  logic [DATA_W-1:0] ex_ALUResult;
  logic [DATA_W-1:0] ex_StoreData;

  // ID-stage source registers used for load-use detection.
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;

  // Data-memory port.
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;

  // Forwarding qualifiers and data.
  logic              MEM_RegWrite;
  logic [REG_AW-1:0] MEM_WriteRegister;
  logic [DATA_W-1:0] MEM_ALUResult;
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_WriteRegister;
  logic [DATA_W-1:0] WB_WriteData;

  // Status.
  logic              load_use_hazard;
  logic [CNT_W-1:0]  retired_count;

  // Core side: drives the EX stage and memory read data, consumes everything else.
  modport master (
    output stall, flush_ex,
    output ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
    output ex_WriteRegister, ex_ALUResult, ex_StoreData,
    output id_rs, id_rt, mem_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    input  MEM_RegWrite, MEM_WriteRegister, MEM_ALUResult,
    input  WB_RegWrite, WB_WriteRegister, WB_WriteData,
    input  load_use_hazard, retired_count
  );

  // Pipeline-register side.
  modport slave (
    input  stall, flush_ex,
    input  ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
    input  ex_WriteRegister, ex_ALUResult, ex_StoreData,
    input  id_rs, id_rt, mem_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    output MEM_RegWrite, MEM_WriteRegister, MEM_ALUResult,
    output WB_RegWrite, WB_WriteRegister, WB_WriteData,
    output load_use_hazard, retired_count
  );
endinterface

// File: rtl/ex_wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers, data-memory strobes, forwarding qualifiers, load-use flag, retire counter.
// ex_* reaches MEM_* after 1 cycle and WB_* after 2 cycles; load_use_hazard is combinational.
// stall holds both stages and suppresses mem_write so a held store writes once; flush_ex inserts a bubble.
module ex_wb_pipe_regs #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  ex_wb_pipe_regs_if.slave  bus
);

  // EX/MEM stage state.
  logic              memValid;
  logic              memRegWrite;
  logic              memMemRead;
  logic              memMemWrite;
  logic              memMemtoReg;
  logic [REG_AW-1:0] memWriteReg;
  logic [DATA_W-1:0] memAluResult;
  logic [DATA_W-1:0] memStoreData;

  // MEM/WB stage state.
  logic              wbValid;
  logic              wbRegWrite;
  logic [REG_AW-1:0] wbWriteReg;
  logic [DATA_W-1:0] wbWriteData;

  logic [CNT_W-1:0]  retiredCount;

  // A real EX instruction that has not been flushed enters MEM; anything else becomes a bubble.
  logic exTakes;
  logic exDestNonZero;
  logic exSrcMatch;

  assign exTakes       = bus.ex_valid & ~bus.flush_ex;
  assign exDestNonZero = |bus.ex_WriteRegister;
  assign exSrcMatch    = (bus.ex_WriteRegister == bus.id_rs) |
                         (bus.ex_WriteRegister == bus.id_rt);

  // EX/MEM capture: hold on stall, bubble on flush/invalid, and never qualify a write to $zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      memValid     <= 1'b0;
      memRegWrite  <= 1'b0;
      memMemRead   <= 1'b0;
      memMemWrite  <= 1'b0;
      memMemtoReg  <= 1'b0;
      memWriteReg  <= '0;
      memAluResult <= '0;
      memStoreData <= '0;
    end else if (!bus.stall) begin
      if (exTakes) begin
        memValid     <= 1'b1;
        memRegWrite  <= bus.ex_RegWrite & exDestNonZero;
        memMemRead   <= bus.ex_MemRead;
        memMemWrite  <= bus.ex_MemWrite;
        memMemtoReg  <= bus.ex_MemtoReg;
        memWriteReg  <= bus.ex_WriteRegister;
        memAluResult <= bus.ex_ALUResult;
        memStoreData <= bus.ex_StoreData;
      end else begin
        memValid     <= 1'b0;
        memRegWrite  <= 1'b0;
        memMemRead   <= 1'b0;
        memMemWrite  <= 1'b0;
        memMemtoReg  <= 1'b0;
        memWriteReg  <= '0;
        memAluResult <= '0;
        memStoreData <= '0;
      end
    end
  end

  // MEM/WB capture: pick load data or ALU result; a held load re-samples mem_rdata when released.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbWriteReg  <= '0;
      wbWriteData <= '0;
    end else if (!bus.stall) begin
      wbValid     <= memValid;
      wbRegWrite  <= memRegWrite;
      wbWriteReg  <= memWriteReg;
      wbWriteData <= memMemtoReg ? bus.mem_rdata : memAluResult;
    end
  end

  // Retire counter: one count per valid entry entering MEM/WB, silently wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      retiredCount <= '0;
    end else if (!bus.stall && memValid) begin
      retiredCount <= retiredCount + CNT_W'(1);
    end
  end

  // Memory strobes; the store strobe is gated by stall so a held store fires only on release.
  assign bus.mem_addr  = memAluResult;
  assign bus.mem_wdata = memStoreData;
  assign bus.mem_read  = memValid & memMemRead;
  assign bus.mem_write = memValid & memMemWrite & ~bus.stall;

  // Forwarding qualifiers and data.
  assign bus.MEM_RegWrite      = memRegWrite;
  assign bus.MEM_WriteRegister = memWriteReg;
  assign bus.MEM_ALUResult     = memAluResult;
  assign bus.WB_RegWrite       = wbRegWrite;
  assign bus.WB_WriteRegister  = wbWriteReg;
  assign bus.WB_WriteData      = wbWriteData;

  // Load in EX whose destination is read by ID: ID must stall one cycle. Not masked by stall.
  assign bus.load_use_hazard = bus.ex_valid & bus.ex_MemRead & bus.ex_RegWrite &
                               exDestNonZero & exSrcMatch;

  assign bus.retired_count = retiredCount;

endmodule

// File: tb/tb_ex_wb_pipe_regs.sv
// Randomised and directed bench for ex_wb_pipe_regs against an instruction-level pipeline model.
// Second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
// Stall and flush are driven directly; the bench holds flush during stall as upstream must.
module tb_ex_wb_pipe_regs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_wb_pipe_regs_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) busA ();
  ex_wb_pipe_regs_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  busB ();

  ex_wb_pipe_regs #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dutA (.clk(clk), .reset(reset), .bus(busA));
  ex_wb_pipe_regs #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dutB (.clk(clk), .reset(reset), .bus(busB));

  // Instance B sees exactly the stimulus of instance A.
  assign busB.stall            = busA.stall;
  assign busB.flush_ex         = busA.flush_ex;
  assign busB.ex_valid         = busA.ex_valid;
  assign busB.ex_RegWrite      = busA.ex_RegWrite;
  assign busB.ex_MemRead       = busA.ex_MemRead;
  assign busB.ex_MemWrite      = busA.ex_MemWrite;
  assign busB.ex_MemtoReg      = busA.ex_MemtoReg;
  assign busB.ex_WriteRegister = busA.ex_WriteRegister;
  assign busB.ex_ALUResult     = busA.ex_ALUResult;
  assign busB.ex_StoreData     = busA.ex_StoreData;
  assign busB.id_rs            = busA.id_rs;
  assign busB.id_rt            = busA.id_rt;
  assign busB.mem_rdata        = busA.mem_rdata;

  int nTests = 0;
  int nFail  = 0;

  // Model: the instruction sitting in each stage, plus the number retired so far.
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memtoReg;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] sdata;
  } memEntry_t;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wbEntry_t;

  memEntry_t   mMem;
  wbEntry_t    mWb;
  logic [31:0] mCount;
  logic [3:0]  mCount4;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    memEntry_t nextMem;
    wbEntry_t  nextWb;
    if (reset) begin
      mMem    = '0;
      mWb     = '0;
      mCount  = '0;
      mCount4 = '0;
    end else if (!busA.stall) begin
      nextWb.valid    = mMem.valid;
      nextWb.regWrite = mMem.regWrite;
      nextWb.wreg     = mMem.wreg;
      nextWb.wdata    = mMem.memtoReg ? busA.mem_rdata : mMem.alu;
      if (mMem.valid) begin
        mCount  = mCount + 32'd1;
        mCount4 = mCount4 + 4'd1;
      end
      nextMem = '0;
      if (busA.ex_valid && !busA.flush_ex) begin
        nextMem.valid    = 1'b1;
        nextMem.regWrite = busA.ex_RegWrite && (busA.ex_WriteRegister != 5'd0);
        nextMem.memRead  = busA.ex_MemRead;
        nextMem.memWrite = busA.ex_MemWrite;
        nextMem.memtoReg = busA.ex_MemtoReg;
        nextMem.wreg     = busA.ex_WriteRegister;
        nextMem.alu      = busA.ex_ALUResult;
        nextMem.sdata    = busA.ex_StoreData;
      end
      mMem = nextMem;
      mWb  = nextWb;
    end
  endtask

  // Load in EX whose destination (not $zero) is a source of the ID instruction.
  function automatic logic expHazard();
    if (!busA.ex_valid || !busA.ex_MemRead || !busA.ex_RegWrite) return 1'b0;
    if (busA.ex_WriteRegister == 5'd0) return 1'b0;
    return (busA.ex_WriteRegister == busA.id_rs) || (busA.ex_WriteRegister == busA.id_rt);
  endfunction

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    busA.stall            = 1'b0;
    busA.flush_ex         = 1'b0;
    busA.ex_valid         = 1'b0;
    busA.ex_RegWrite      = 1'b0;
    busA.ex_MemRead       = 1'b0;
    busA.ex_MemWrite      = 1'b0;
    busA.ex_MemtoReg      = 1'b0;
    busA.ex_WriteRegister = 5'd0;
    busA.ex_ALUResult     = 32'd0;
    busA.ex_StoreData     = 32'd0;
    busA.id_rs            = 5'd0;
    busA.id_rt            = 5'd0;
    busA.mem_rdata        = 32'd0;
    #1;
  endtask

  task automatic driveOp(input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] sd);
    busA.stall            = 1'b0;
    busA.flush_ex         = 1'b0;
    busA.ex_valid         = 1'b1;
    busA.ex_RegWrite      = rw;
    busA.ex_MemRead       = mr;
    busA.ex_MemWrite      = mw;
    busA.ex_MemtoReg      = m2r;
    busA.ex_WriteRegister = wreg;
    busA.ex_ALUResult     = alu;
    busA.ex_StoreData     = sd;
    busA.id_rs            = 5'd0;
    busA.id_rt            = 5'd0;
    #1;
  endtask

  // Reset wins over stall and flush; every output reads zero afterwards.
  task automatic test_reset();
    logic [175:0] act;
    driveOp(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'hCAFE_0001, 32'h1111_2222);
    busA.stall    = 1'b1;
    busA.flush_ex = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    setIdle();
    act = {busA.mem_addr, busA.mem_wdata, busA.mem_read, busA.mem_write, busA.MEM_RegWrite,
           busA.MEM_WriteRegister, busA.MEM_ALUResult, busA.WB_RegWrite, busA.WB_WriteRegister,
           busA.WB_WriteData, busA.load_use_hazard, busA.retired_count};
    nTests++;
    if (act !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got %h required 0", act);
    end
    nTests++;
    if (busB.retired_count !== 4'd0) begin
      nFail++;
      $display("FAIL reset_count_b: got %h required 0", busB.retired_count);
    end
  endtask

  // ALU op flows to MEM then WB and retires once.
  task automatic test_alu();
    driveOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_1234, 32'd0);
    tick();
    setIdle();
    nTests++;
    if ({busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.MEM_ALUResult} !== {1'b1, 5'd8, 32'h1234}) begin
      nFail++;
      $display("FAIL alu_mem_stage: got %b/%0d/%h required 1/8/1234",
               busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.MEM_ALUResult);
    end
    tick();
    nTests++;
    if ({busA.WB_RegWrite, busA.WB_WriteRegister, busA.WB_WriteData, busA.retired_count} !==
        {1'b1, 5'd8, 32'h1234, 32'd1}) begin
      nFail++;
      $display("FAIL alu_wb_stage: got %b/%0d/%h cnt %0d required 1/8/1234 cnt 1",
               busA.WB_RegWrite, busA.WB_WriteRegister, busA.WB_WriteData, busA.retired_count);
    end
  endtask

  // Load raises the hazard in EX, then strobes mem_read and writes back memory data.
  task automatic test_load_use();
    driveOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0100, 32'd0);
    busA.id_rt = 5'd9;
    #1;
    nTests++;
    if (busA.load_use_hazard !== 1'b1) begin
      nFail++;
      $display("FAIL load_use_flag: got %b required 1", busA.load_use_hazard);
    end
    tick();
    setIdle();
    busA.mem_rdata = 32'hDEAD_BEEF;
    #1;
    nTests++;
    if ({busA.mem_read, busA.mem_addr} !== {1'b1, 32'h0000_0100}) begin
      nFail++;
      $display("FAIL load_mem_read: got %b/%h required 1/00000100", busA.mem_read, busA.mem_addr);
    end
    tick();
    nTests++;
    if ({busA.WB_RegWrite, busA.WB_WriteRegister, busA.WB_WriteData} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
      nFail++;
      $display("FAIL load_wb: got %b/%0d/%h required 1/9/deadbeef",
               busA.WB_RegWrite, busA.WB_WriteRegister, busA.WB_WriteData);
    end
  endtask

  // Store held in MEM for 3 stalled cycles: one write strobe, only after release.
  task automatic test_store_stall();
    logic [31:0] cntHeld;
    logic [31:0] wbHeld;
    driveOp(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'h5555_AAAA);
    tick();
    setIdle();
    busA.stall = 1'b1;
    #1;
    cntHeld = mCount;
    wbHeld  = mWb.wdata;
    for (int i = 0; i < 3; i++) begin
      nTests++;
      if (busA.mem_write !== 1'b0) begin
        nFail++;
        $display("FAIL store_stall_strobe[%0d]: got %b required 0", i, busA.mem_write);
      end
      tick();
      nTests++;
      if ({busA.retired_count, busA.WB_WriteData} !== {cntHeld, wbHeld}) begin
        nFail++;
        $display("FAIL store_stall_hold[%0d]: got cnt %0d wb %h required cnt %0d wb %h",
                 i, busA.retired_count, busA.WB_WriteData, cntHeld, wbHeld);
      end
    end
    busA.stall = 1'b0;
    #1;
    nTests++;
    if ({busA.mem_write, busA.mem_wdata, busA.mem_addr} !== {1'b1, 32'h5555_AAAA, 32'h0000_0200}) begin
      nFail++;
      $display("FAIL store_release: got %b/%h/%h required 1/5555aaaa/00000200",
               busA.mem_write, busA.mem_wdata, busA.mem_addr);
    end
    tick();
    nTests++;
    if (busA.mem_write !== 1'b0) begin
      nFail++;
      $display("FAIL store_single_strobe: got %b required 0", busA.mem_write);
    end
  endtask

  // $zero destination never qualifies a write and never flags a hazard.
  task automatic test_zero_dest();
    driveOp(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0077, 32'd0);
    busA.id_rs = 5'd0;
    #1;
    nTests++;
    if (busA.load_use_hazard !== 1'b0) begin
      nFail++;
      $display("FAIL zero_hazard: got %b required 0", busA.load_use_hazard);
    end
    tick();
    setIdle();
    nTests++;
    if (busA.MEM_RegWrite !== 1'b0) begin
      nFail++;
      $display("FAIL zero_mem_regwrite: got %b required 0", busA.MEM_RegWrite);
    end
    tick();
    nTests++;
    if (busA.WB_RegWrite !== 1'b0) begin
      nFail++;
      $display("FAIL zero_wb_regwrite: got %b required 0", busA.WB_RegWrite);
    end
  endtask

  // Flush is ignored under stall; without stall it bubbles EX while MEM/WB advances.
  task automatic test_flush_stall();
    logic [31:0] cntBase;
    driveOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_00AA, 32'd0);
    tick();
    driveOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h0000_00BB, 32'd0);
    busA.flush_ex = 1'b1;
    busA.stall    = 1'b1;
    #1;
    tick();
    nTests++;
    if ({busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.MEM_ALUResult} !== {1'b1, 5'd5, 32'hAA}) begin
      nFail++;
      $display("FAIL flush_under_stall: got %b/%0d/%h required 1/5/aa",
               busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.MEM_ALUResult);
    end
    cntBase = mCount;
    busA.stall = 1'b0;
    #1;
    tick();
    nTests++;
    if ({busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.WB_WriteRegister} !== {1'b0, 5'd0, 5'd5}) begin
      nFail++;
      $display("FAIL flush_bubble: got %b/%0d wb %0d required 0/0 wb 5",
               busA.MEM_RegWrite, busA.MEM_WriteRegister, busA.WB_WriteRegister);
    end
    setIdle();
    tick();
    nTests++;
    if (busA.retired_count !== cntBase + 32'd1) begin
      nFail++;
      $display("FAIL flush_no_retire: got %0d required %0d", busA.retired_count, cntBase + 32'd1);
    end
  endtask

  // Reset with MEM and WB both valid clears everything.
  task automatic test_reset_midstream();
    logic [175:0] act;
    driveOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0003, 32'd0);
    tick();
    driveOp(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_0004, 32'h0000_0044);
    tick();
    setIdle();
    nTests++;
    if ({busA.MEM_RegWrite, busA.WB_RegWrite} !== 2'b11) begin
      nFail++;
      $display("FAIL midstream_full: got %b%b required 11", busA.MEM_RegWrite, busA.WB_RegWrite);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    act = {busA.mem_addr, busA.mem_wdata, busA.mem_read, busA.mem_write, busA.MEM_RegWrite,
           busA.MEM_WriteRegister, busA.MEM_ALUResult, busA.WB_RegWrite, busA.WB_WriteRegister,
           busA.WB_WriteData, busA.load_use_hazard, busA.retired_count};
    nTests++;
    if (act !== '0) begin
      nFail++;
      $display("FAIL midstream_reset: got %h required 0", act);
    end
  endtask

  // Counter wrap: 16 retires from zero leaves the 4-bit counter at 0 and the 32-bit one at 16.
  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      driveOp(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'(i), 32'd0);
      tick();
    end
    setIdle();
    nTests++;
    if ({busB.retired_count, busA.retired_count} !== {4'hF, 32'd15}) begin
      nFail++;
      $display("FAIL wrap_before: got b=%0d a=%0d required b=15 a=15", busB.retired_count, busA.retired_count);
    end
    tick();
    nTests++;
    if ({busB.retired_count, busA.retired_count} !== {4'h0, 32'd16}) begin
      nFail++;
      $display("FAIL wrap_after: got b=%0d a=%0d required b=0 a=16", busB.retired_count, busA.retired_count);
    end
  endtask

  // Random traffic with stall, flush, loads, stores and occasional reset against the model.
  task automatic test_random();
    logic [142:0] act;
    logic [142:0] exp;
    for (int c = 0; c < 600; c++) begin
      reset                 = ($urandom_range(0, 59) == 0);
      busA.stall            = ($urandom_range(0, 4) == 0);
      busA.flush_ex         = ($urandom_range(0, 9) == 0);
      busA.ex_valid         = ($urandom_range(0, 4) != 0);
      busA.ex_RegWrite      = 1'($urandom);
      busA.ex_MemRead       = 1'($urandom);
      busA.ex_MemWrite      = 1'($urandom);
      busA.ex_MemtoReg      = 1'($urandom);
      busA.ex_WriteRegister = 5'($urandom_range(0, 3));
      busA.ex_ALUResult     = $urandom;
      busA.ex_StoreData     = $urandom;
      busA.id_rs            = 5'($urandom_range(0, 3));
      busA.id_rt            = 5'($urandom_range(0, 3));
      busA.mem_rdata        = $urandom;
      #1;
      act = {busA.mem_addr, busA.mem_wdata, busA.mem_read, busA.mem_write, busA.MEM_RegWrite,
             busA.MEM_WriteRegister, busA.MEM_ALUResult, busA.WB_RegWrite, busA.WB_WriteRegister,
             busA.WB_WriteData, busA.load_use_hazard};
      exp = {mMem.alu, mMem.sdata, mMem.valid & mMem.memRead,
             mMem.valid & mMem.memWrite & ~busA.stall, mMem.regWrite, mMem.wreg, mMem.alu,
             mWb.regWrite, mWb.wreg, mWb.wdata, expHazard()};
      nTests++;
      if (act !== exp) begin
        nFail++;
        $display("FAIL random_outputs[%0d]: got %h required %h", c, act, exp);
      end
      nTests++;
      if ({busA.retired_count, busB.retired_count} !== {mCount, mCount4}) begin
        nFail++;
        $display("FAIL random_count[%0d]: got %0d/%0d required %0d/%0d",
                 c, busA.retired_count, busB.retired_count, mCount, mCount4);
      end
      tick();
    end
    reset = 1'b0;
    setIdle();
  endtask

  initial begin
    reset   = 1'b1;
    mMem    = '0;
    mWb     = '0;
    mCount  = '0;
    mCount4 = '0;
    setIdle();
    test_reset();
    test_alu();
    test_load_use();
    test_store_stall();
    test_zero_dest();
    test_flush_stall();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
